// File: rtl/lpif_ustrm_arb.sv
// lpif_ustrm_arb
//   Two-requester round-robin arbiter feeding the upstream LPIF data channel.
//   A grant is held for the whole burst and released only by an accepted
//   last beat. Accepted beats appear on ustrm_* one cycle later through a
//   single output register that holds its word until the sink consumes it.
//
// Ports
//   lclk, rst                    clock, asynchronous active-high reset
//   link_state[3:0]              current LPIF link state
//   reqN_vld/_data/_last/_rdy    requester N beat handshake (N = 0, 1)
//   ustrm_state[3:0]             link_state delayed one cycle
//   ustrm_protid[1:0]            PROTID0/PROTID1 of the beat's source
//   ustrm_data[31:0]             beat payload
//   ustrm_dvalid, ustrm_valid    word present on the channel
//   ustrm_crc, ustrm_crc_valid   tied low
//   ustrm_ready                  sink can take a word this cycle
//
// Optional feature (macro LPIF_USTRM_ARB_PERF_CNT_EN)
//   perf_clr                     synchronous clear of the beat counters
//   beat_cnt0, beat_cnt1[15:0]   saturating count of beats consumed upstream
//                                per requester

module lpif_ustrm_arb #(
    parameter logic [1:0] PROTID0      = 2'd0,
    parameter logic [1:0] PROTID1      = 2'd1,
    parameter logic [3:0] ACTIVE_STATE = 4'h1
) (
    input  logic        lclk,
    input  logic        rst,
    input  logic [3:0]  link_state,
    input  logic        req0_vld,
    input  logic [31:0] req0_data,
    input  logic        req0_last,
    output logic        req0_rdy,
    input  logic        req1_vld,
    input  logic [31:0] req1_data,
    input  logic        req1_last,
    output logic        req1_rdy,
    output logic [3:0]  ustrm_state,
    output logic [1:0]  ustrm_protid,
    output logic [31:0] ustrm_data,
    output logic        ustrm_dvalid,
    output logic        ustrm_crc,
    output logic        ustrm_crc_valid,
    output logic        ustrm_valid,
    input  logic        ustrm_ready
`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
    ,
    input  logic        perf_clr,
    output logic [15:0] beat_cnt0,
    output logic [15:0] beat_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t state, state_nxt;
    logic   rr_ptr;
    logic   link_active;
    logic   can_load;
    logic   acc0, acc1;

    assign link_active = (link_state == ACTIVE_STATE);
    // The output register may be refilled when empty or being drained this cycle.
    assign can_load    = !ustrm_valid || ustrm_ready;
    assign acc0        = req0_vld && req0_rdy;
    assign acc1        = req1_vld && req1_rdy;

    // State register
    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (link_active) begin
                    if (req0_vld && req1_vld) begin
                        state_nxt = rr_ptr ? GRANT1 : GRANT0;
                    end else if (req0_vld) begin
                        state_nxt = GRANT0;
                    end else if (req1_vld) begin
                        state_nxt = GRANT1;
                    end
                end
            end
            GRANT0: begin
                if (acc0 && req0_last) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (acc1 && req1_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: nothing is accepted in IDLE or while the link is down.
    always_comb begin
        req0_rdy = (state == GRANT0) && link_active && can_load;
        req1_rdy = (state == GRANT1) && link_active && can_load;
    end

    // Round-robin pointer moves to the other requester when a burst finishes.
    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (acc0 && req0_last) begin
            rr_ptr <= 1'b1;
        end else if (acc1 && req1_last) begin
            rr_ptr <= 1'b0;
        end
    end

    // Output register: load on accept, clear valid on a drain with no refill.
    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            ustrm_valid  <= 1'b0;
            ustrm_dvalid <= 1'b0;
            ustrm_data   <= '0;
            ustrm_protid <= '0;
        end else if (acc0) begin
            ustrm_valid  <= 1'b1;
            ustrm_dvalid <= 1'b1;
            ustrm_data   <= req0_data;
            ustrm_protid <= PROTID0;
        end else if (acc1) begin
            ustrm_valid  <= 1'b1;
            ustrm_dvalid <= 1'b1;
            ustrm_data   <= req1_data;
            ustrm_protid <= PROTID1;
        end else if (ustrm_ready) begin
            ustrm_valid  <= 1'b0;
            ustrm_dvalid <= 1'b0;
        end
    end

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            ustrm_state <= '0;
        end else begin
            ustrm_state <= link_state;
        end
    end

    assign ustrm_crc       = 1'b0;
    assign ustrm_crc_valid = 1'b0;

`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
    logic src_p1;    // requester that owns the word in the output register
    logic consume;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign consume = ustrm_valid && ustrm_ready;

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            src_p1 <= 1'b0;
        end else if (acc0) begin
            src_p1 <= 1'b0;
        end else if (acc1) begin
            src_p1 <= 1'b1;
        end
    end

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            beat_cnt0 <= '0;
            beat_cnt1 <= '0;
        end else if (perf_clr) begin
            beat_cnt0 <= '0;
            beat_cnt1 <= '0;
        end else if (consume) begin
            if (src_p1) begin
                beat_cnt1 <= sat_inc(beat_cnt1);
            end else begin
                beat_cnt0 <= sat_inc(beat_cnt0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lpif_ustrm_arb.sv
// tb_lpif_ustrm_arb
//   Bench for lpif_ustrm_arb. Per-requester driver processes present beats
//   from queues; expected upstream words are queued when stimulus is set up
//   and a monitor pops and compares each word consumed upstream.
//   Inputs change at posedge+1/+2, outputs are sampled on the falling edge.

module tb_lpif_ustrm_arb;

    logic        lclk;
    logic        rst;
    logic [3:0]  link_state;
    logic        req0_vld, req1_vld;
    logic [31:0] req0_data, req1_data;
    logic        req0_last, req1_last;
    logic        req0_rdy, req1_rdy;
    logic [3:0]  ustrm_state;
    logic [1:0]  ustrm_protid;
    logic [31:0] ustrm_data;
    logic        ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid;
    logic        ustrm_ready;
`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
    logic        perf_clr;
    logic [15:0] beat_cnt0, beat_cnt1;
`endif

    lpif_ustrm_arb dut (
        .lclk            (lclk),
        .rst             (rst),
        .link_state      (link_state),
        .req0_vld        (req0_vld),
        .req0_data       (req0_data),
        .req0_last       (req0_last),
        .req0_rdy        (req0_rdy),
        .req1_vld        (req1_vld),
        .req1_data       (req1_data),
        .req1_last       (req1_last),
        .req1_rdy        (req1_rdy),
        .ustrm_state     (ustrm_state),
        .ustrm_protid    (ustrm_protid),
        .ustrm_data      (ustrm_data),
        .ustrm_dvalid    (ustrm_dvalid),
        .ustrm_crc       (ustrm_crc),
        .ustrm_crc_valid (ustrm_crc_valid),
        .ustrm_valid     (ustrm_valid),
        .ustrm_ready     (ustrm_ready)
`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
        ,
        .perf_clr        (perf_clr),
        .beat_cnt0       (beat_cnt0),
        .beat_cnt1       (beat_cnt1)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [1:0]  protid;
        logic [31:0] data;
    } word_t;

    beat_t q0[$];
    beat_t q1[$];
    word_t exp_q[$];

    int vecs     = 0;
    int errs     = 0;
    int consumed = 0;
    bit en0      = 1'b1;
    bit en1      = 1'b1;
    bit acc0_s, acc1_s;

    initial begin
        lclk = 1'b0;
        forever #5 lclk = ~lclk;
    end

    // Requester 0 driver
    initial begin
        req0_vld  = 1'b0;
        req0_data = '0;
        req0_last = 1'b0;
        forever begin
            @(negedge lclk);
            acc0_s = req0_vld && req0_rdy;
            @(posedge lclk);
            #1;
            if (acc0_s && q0.size() > 0) void'(q0.pop_front());
            if (en0 && q0.size() > 0) begin
                req0_vld  = 1'b1;
                req0_data = q0[0].data;
                req0_last = q0[0].last;
            end else begin
                req0_vld  = 1'b0;
                req0_last = 1'b0;
            end
        end
    end

    // Requester 1 driver
    initial begin
        req1_vld  = 1'b0;
        req1_data = '0;
        req1_last = 1'b0;
        forever begin
            @(negedge lclk);
            acc1_s = req1_vld && req1_rdy;
            @(posedge lclk);
            #1;
            if (acc1_s && q1.size() > 0) void'(q1.pop_front());
            if (en1 && q1.size() > 0) begin
                req1_vld  = 1'b1;
                req1_data = q1[0].data;
                req1_last = q1[0].last;
            end else begin
                req1_vld  = 1'b0;
                req1_last = 1'b0;
            end
        end
    end

    // Upstream monitor / scoreboard
    initial begin
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [1:0]  prev_prot;
        word_t       w;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_prot  = '0;
        forever begin
            @(negedge lclk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    vecs++;
                    if (ustrm_valid !== 1'b1 || ustrm_data !== prev_data || ustrm_protid !== prev_prot) begin
                        errs++;
                        $display("FAIL hold_stable: got valid=%b data=%h protid=%0d, need valid=1 data=%h protid=%0d",
                                 ustrm_valid, ustrm_data, ustrm_protid, prev_data, prev_prot);
                    end
                end
                if (ustrm_valid === 1'b1 && ustrm_ready === 1'b1) begin
                    consumed++;
                    vecs++;
                    if (exp_q.size() == 0) begin
                        errs++;
                        $display("FAIL unexpected_beat: got data=%h protid=%0d, need no beat", ustrm_data, ustrm_protid);
                    end else begin
                        w = exp_q.pop_front();
                        if ({ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid} !== {w.protid, w.data, 3'b100}) begin
                            errs++;
                            $display("FAIL beat: got protid=%0d data=%h dvalid=%b crc=%b crcv=%b, need protid=%0d data=%h dvalid=1 crc=0 crcv=0",
                                     ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, w.protid, w.data);
                        end
                    end
                end
                prev_stall = (ustrm_valid === 1'b1) && (ustrm_ready !== 1'b1);
                prev_data  = ustrm_data;
                prev_prot  = ustrm_protid;
            end
        end
    end

    task automatic push_beat(input int req, input logic [31:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        if (req == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic push_exp(input logic [1:0] protid, input logic [31:0] data);
        word_t w;
        w.protid = protid;
        w.data   = data;
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge lclk);
            #2;
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge lclk);
        #2;
    endtask

    task automatic pulse_reset();
        @(posedge lclk);
        #2;
        rst = 1'b1;
        @(negedge lclk);
        @(posedge lclk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge lclk);
        @(negedge lclk);
        vecs++;
        if ({ustrm_valid, ustrm_dvalid, req0_rdy, req1_rdy, ustrm_crc, ustrm_crc_valid} !== 6'b0) begin
            errs++;
            $display("FAIL reset_flags: got valid=%b dvalid=%b rdy0=%b rdy1=%b crc=%b crcv=%b, need all 0",
                     ustrm_valid, ustrm_dvalid, req0_rdy, req1_rdy, ustrm_crc, ustrm_crc_valid);
        end
        vecs++;
        if (ustrm_data !== 32'h0 || ustrm_protid !== 2'd0) begin
            errs++;
            $display("FAIL reset_data: got data=%h protid=%0d, need 0/0", ustrm_data, ustrm_protid);
        end
        vecs++;
        if (ustrm_state !== 4'h0) begin
            errs++;
            $display("FAIL reset_state: got %h, need 0", ustrm_state);
        end
        @(posedge lclk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_state_track();
        @(posedge lclk);
        #2;
        link_state = 4'h5;
        @(negedge lclk);
        vecs++;
        if (ustrm_state !== 4'h1) begin
            errs++;
            $display("FAIL state_delay: got %h, need 1", ustrm_state);
        end
        @(negedge lclk);
        vecs++;
        if (ustrm_state !== 4'h5) begin
            errs++;
            $display("FAIL state_follow: got %h, need 5", ustrm_state);
        end
        @(posedge lclk);
        #2;
        link_state = 4'h1;
        @(posedge lclk);
        #2;
    endtask

    task automatic test_burst();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            push_beat(0, 32'hA000_0000 + i, (i == 2));
            push_exp(2'd0, 32'hA000_0000 + i);
        end
        @(posedge lclk);
        #2;
        @(negedge lclk);
        vecs++;
        if (req0_rdy !== 1'b0 || ustrm_valid !== 1'b0) begin
            errs++;
            $display("FAIL burst_idle: got rdy0=%b valid=%b, need 0/0", req0_rdy, ustrm_valid);
        end
        @(negedge lclk);
        vecs++;
        if (req0_rdy !== 1'b1) begin
            errs++;
            $display("FAIL burst_grant: got rdy0=%b, need 1", req0_rdy);
        end
        @(negedge lclk);
        vecs++;
        if (ustrm_valid !== 1'b1 || ustrm_data !== 32'hA000_0000) begin
            errs++;
            $display("FAIL burst_latency: got valid=%b data=%h, need 1/a0000000", ustrm_valid, ustrm_data);
        end
        wait_idle(50, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL burst_drain: got %0d words left, need 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            push_beat(0, 32'h0C00_0000 + i, 1'b1);
            push_beat(1, 32'h1C00_0000 + i, 1'b1);
            push_exp(2'd0, 32'h0C00_0000 + i);
            push_exp(2'd1, 32'h1C00_0000 + i);
        end
        wait_idle(80, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL rr_drain: got %0d words left, need 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int base;
        base = consumed;
        for (int i = 0; i < 6; i++) begin
            push_beat(0, 32'hB000_0000 + i, (i == 5));
            push_exp(2'd0, 32'hB000_0000 + i);
        end
        for (int i = 0; i < 40 && consumed < base + 2; i++) begin
            @(posedge lclk);
            #2;
        end
        vecs++;
        if (consumed < base + 2) begin
            errs++;
            $display("FAIL bp_start: got %0d beats, need 2", consumed - base);
        end
        ustrm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge lclk);
            vecs++;
            if (req0_rdy !== 1'b0 || ustrm_valid !== 1'b1) begin
                errs++;
                $display("FAIL bp_stall%0d: got rdy0=%b valid=%b, need 0/1", i, req0_rdy, ustrm_valid);
            end
        end
        @(posedge lclk);
        #2;
        ustrm_ready = 1'b1;
        wait_idle(50, ok);
        vecs++;
        if (!ok || consumed != base + 6) begin
            errs++;
            $display("FAIL bp_count: got %0d beats (%0d pending), need 6", consumed - base, exp_q.size());
        end
    endtask

    task automatic test_vld_drop();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            push_beat(0, 32'hD000_0000 + i, (i == 2));
            push_exp(2'd0, 32'hD000_0000 + i);
        end
        for (int i = 0; i < 40 && q0.size() > 2; i++) begin
            @(posedge lclk);
            #2;
        end
        en0 = 1'b0;
        push_beat(1, 32'hD100_0000, 1'b1);
        push_exp(2'd1, 32'hD100_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge lclk);
            vecs++;
            if (req1_rdy !== 1'b0) begin
                errs++;
                $display("FAIL vld_drop_hold%0d: got rdy1=%b, need 0", i, req1_rdy);
            end
        end
        @(posedge lclk);
        #2;
        en0 = 1'b1;
        wait_idle(50, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL vld_drop_drain: got %0d words left, need 0", exp_q.size());
        end
    endtask

    task automatic test_link_drop();
        bit ok;
        int base;
        base = consumed;
        for (int i = 0; i < 5; i++) begin
            push_beat(1, 32'hE000_0000 + i, (i == 4));
            push_exp(2'd1, 32'hE000_0000 + i);
        end
        for (int i = 0; i < 40 && consumed < base + 1; i++) begin
            @(posedge lclk);
            #2;
        end
        link_state = 4'h0;
        push_beat(0, 32'hE100_0000, 1'b1);
        push_exp(2'd0, 32'hE100_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge lclk);
            vecs++;
            if (req1_rdy !== 1'b0 || req0_rdy !== 1'b0) begin
                errs++;
                $display("FAIL link_stall%0d: got rdy1=%b rdy0=%b, need 0/0", i, req1_rdy, req0_rdy);
            end
        end
        vecs++;
        if (ustrm_valid !== 1'b0 || ustrm_state !== 4'h0) begin
            errs++;
            $display("FAIL link_drain: got valid=%b state=%h, need 0/0", ustrm_valid, ustrm_state);
        end
        @(posedge lclk);
        #2;
        link_state = 4'h1;
        wait_idle(60, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL link_resume: got %0d words left, need 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ustrm_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_beat(1, 32'hF000_0000 + i, (i == 5));
        end
        for (int i = 0; i < 20 && ustrm_valid !== 1'b1; i++) begin
            @(posedge lclk);
            #2;
        end
        vecs++;
        if (ustrm_valid !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_setup: got valid=%b, need 1", ustrm_valid);
        end
        en1 = 1'b0;
        q1.delete();
        exp_q.delete();
        rst = 1'b1;
        @(negedge lclk);
        vecs++;
        if (ustrm_valid !== 1'b0 || ustrm_dvalid !== 1'b0 || req1_rdy !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_clear: got valid=%b dvalid=%b rdy1=%b, need 0/0/0", ustrm_valid, ustrm_dvalid, req1_rdy);
        end
        @(posedge lclk);
        #2;
        rst = 1'b0;
        en1 = 1'b1;
        ustrm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge lclk);
            vecs++;
            if (ustrm_valid !== 1'b0) begin
                errs++;
                $display("FAIL rstmid_quiet%0d: got valid=%b, need 0", i, ustrm_valid);
            end
        end
        @(posedge lclk);
        #2;
        // rr_ptr was 1 before the reset; after it requester 0 must win.
        push_beat(0, 32'hF100_0000, 1'b1);
        push_beat(1, 32'hF200_0000, 1'b1);
        push_exp(2'd0, 32'hF100_0000);
        push_exp(2'd1, 32'hF200_0000);
        wait_idle(40, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL rstmid_rr: got %0d words left, need 0", exp_q.size());
        end
    endtask

`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        bit ok;
        perf_clr = 1'b1;
        @(posedge lclk);
        #2;
        perf_clr = 1'b0;
        @(negedge lclk);
        vecs++;
        if (beat_cnt0 !== 16'h0 || beat_cnt1 !== 16'h0) begin
            errs++;
            $display("FAIL perf_clr0: got %h/%h, need 0/0", beat_cnt0, beat_cnt1);
        end
        for (int i = 0; i < 70000; i++) begin
            push_beat(0, i, (i == 69999));
            push_exp(2'd0, i);
        end
        wait_idle(71000, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL perf_drain: got %0d words left, need 0", exp_q.size());
        end
        @(negedge lclk);
        vecs++;
        if (beat_cnt0 !== 16'hFFFF || beat_cnt1 !== 16'h0) begin
            errs++;
            $display("FAIL perf_sat: got %h/%h, need ffff/0", beat_cnt0, beat_cnt1);
        end
        @(posedge lclk);
        #2;
        perf_clr = 1'b1;
        @(posedge lclk);
        #2;
        perf_clr = 1'b0;
        @(negedge lclk);
        vecs++;
        if (beat_cnt0 !== 16'h0) begin
            errs++;
            $display("FAIL perf_clr1: got %h, need 0", beat_cnt0);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        link_state  = 4'h1;
        ustrm_ready = 1'b1;
`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
        perf_clr    = 1'b0;
`endif
        test_reset();
        test_state_track();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_vld_drop();
        test_link_drop();
        test_reset_mid();
`ifdef LPIF_USTRM_ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #3000000;
        errs++;
        $display("FAIL watchdog: got no completion, need finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
